regfile_write_sequencer: RTL and testbench

Owns the single write port (`RegWrite`, `WriteRegister`, `WriteData`) of the 32x32 `registerFile`. After reset it clears registers 1..31 with an internal sweep. It then shares the write port between two writeback requesters, A (ALU) and B (load unit), using round-robin arbitration and a req/ack handshake. All write-port outputs are registered, so the register file always sees glitch-free, clock-aligned write controls.

---
 rtl/regfile_write_sequencer.sv | 92 +++++++++
 tb/tb_regfile_write_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// Write-port owner for a 32-entry register file: clears registers 1..N after reset,
// then round-robin arbitrates two writeback requesters onto a registered write port.
module regfile_write_sequencer #(
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    DATA_WIDTH     = 32,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] DataA,
  output logic                  AckA,
  input  logic                  ReqB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic                  AckB,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  InitDone
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] LAST_REG  = '1;
  localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last_grant;  // 0 = A, 1 = B
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;

  // Zero-latency grant; suppressed while Reset is high so no transfer can occur.
  always_comb begin
    AckA = 1'b0;
    AckB = 1'b0;
    if (state == ST_RUN && !Reset) begin
      AckA = ReqA && (!ReqB || last_grant);
      AckB = ReqB && (!ReqA || !last_grant);
    end
  end

  always_comb begin
    grant_addr = AckB ? AddrB : AddrA;
    grant_data = AckB ? DataB : DataA;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      cnt           <= FIRST_REG;
      last_grant    <= 1'b1;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
      InitDone      <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // Counter saturates at the last register, so the exit is keyed off the
          // write of that register already sitting on the port.
          if (RegWrite && WriteRegister == LAST_REG) begin
            state    <= ST_RUN;
            RegWrite <= 1'b0;
            InitDone <= 1'b1;
          end else begin
            RegWrite      <= 1'b1;
            WriteRegister <= cnt;
            WriteData     <= INIT_VALUE;
            if (cnt != LAST_REG) cnt <= cnt + FIRST_REG;
          end
        end
        default: begin
          InitDone <= 1'b1;
          if (AckA || AckB) begin
            last_grant    <= AckB;
            RegWrite      <= (grant_addr != '0);
            WriteRegister <= grant_addr;
            WriteData     <= grant_data;
          end else begin
            RegWrite <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer with a behavioural register file
// hanging off the write port for readback checks.
module tb_regfile_write_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqA, ReqB;
  logic [4:0]  AddrA, AddrB;
  logic [31:0] DataA, DataB;
  logic        AckA, AckB;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        InitDone;

  int total = 0;
  int bad   = 0;

  logic        preload = 1'b0;
  logic [31:0] rf [32];
  logic [31:0] a_data, b_data;

  regfile_write_sequencer #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(32'h0)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .AckA(AckA),
    .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .AckB(AckB),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .InitDone(InitDone)
  );

  always #5 Clk = ~Clk;

  // Naive register file: any address is writable, so a stray write to 0 shows up.
  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 1; i < 32; i++) rf[i] <= 32'hFFFF_FFFF;
      rf[0] <= 32'h0;
    end else if (RegWrite) begin
      rf[WriteRegister] <= WriteData;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0;
    AddrA = '0; AddrB = '0; DataA = '0; DataB = '0;
    preload = 1'b1;
    step();
    preload = 1'b0;
    step();
    #1;
    check("reset_outs", {RegWrite, WriteRegister, WriteData, InitDone, AckA, AckB}, 64'h0);
    check("preload", {rf[5], rf[31]}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});

    // Clear sweep
    Reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      check($sformatf("sweep_%0d", k), {RegWrite, WriteRegister, WriteData, InitDone},
            {1'b1, 5'(k), 32'h0, 1'b0});
    end
    step();
    check("sweep_done", {RegWrite, InitDone}, {1'b0, 1'b1});
    check("cleared_5_31", {rf[5], rf[31]}, 64'h0);

    // Single requester A
    ReqA = 1'b1; AddrA = 5'd17; DataA = 32'hDEAD_BEEF;
    #1;
    check("single_ack", {AckA, AckB}, {1'b1, 1'b0});
    step();
    ReqA = 1'b0;
    check("single_port", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd17, 32'hDEAD_BEEF});
    step();
    check("single_rf17", rf[17], 32'hDEAD_BEEF);
    check("idle_hold", {RegWrite, WriteRegister, WriteData}, {1'b0, 5'd17, 32'hDEAD_BEEF});

    // Zero register via B (also leaves B as last grant)
    ReqB = 1'b1; AddrB = 5'd0; DataB = 32'd50;
    #1;
    check("zero_ack", {AckA, AckB}, {1'b0, 1'b1});
    step();
    ReqB = 1'b0;
    check("zero_port", {RegWrite, WriteRegister, WriteData}, {1'b0, 5'd0, 32'd50});
    step();
    check("zero_rf0", rf[0], 32'h0);

    // Contention: A then B alternate
    a_data = 32'h11; b_data = 32'h22;
    ReqA = 1'b1; AddrA = 5'd3; DataA = a_data;
    ReqB = 1'b1; AddrB = 5'd4; DataB = b_data;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont_ack_%0d", i), {AckA, AckB}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
      if (i % 2 == 0) begin
        check($sformatf("cont_port_%0d", i), {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd3, a_data});
        a_data = a_data + 32'h100; DataA = a_data;
      end else begin
        check($sformatf("cont_port_%0d", i), {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd4, b_data});
        b_data = b_data + 32'h100; DataB = b_data;
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
    step();
    check("cont_rf3_rf4", {rf[3], rf[4]}, {32'h111, 32'h122});

    // Reset with a request pending, then a mid-sweep reset
    Reset = 1'b1; ReqA = 1'b1; AddrA = 5'd9; DataA = 32'h99;
    #1;
    check("reset_req_noack", {AckA, AckB}, 2'b00);
    step();
    check("reset2_outs", {RegWrite, WriteRegister, WriteData, InitDone, AckA, AckB}, 64'h0);
    Reset = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    check("mid_sweep_10", {RegWrite, WriteRegister, AckA}, {1'b1, 5'd10, 1'b0});
    Reset = 1'b1;
    step();
    check("mid_reset_outs", {RegWrite, WriteRegister, WriteData, InitDone, AckA, AckB}, 64'h0);
    Reset = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      step();
      check($sformatf("resweep_%0d", k), {RegWrite, WriteRegister, InitDone, AckA},
            {1'b1, 5'(k), 1'b0, 1'b0});
    end
    step();
    check("init_req_grant", {RegWrite, InitDone, AckA, AckB}, {1'b0, 1'b1, 1'b1, 1'b0});
    step();
    ReqA = 1'b0;
    check("init_req_port", {RegWrite, WriteRegister, WriteData}, {1'b1, 5'd9, 32'h99});
    step();
    check("init_req_rf9", rf[9], 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
